// File: rtl/alu_pkg.sv
// alu_pkg: ALU_Control operation codes and execution-unit FSM encoding.
// Shared by the ALU control decoder and alu_exec_unit; no ports.
package alu_pkg;
    localparam logic [3:0] ALU_DIV     = 4'b0000;
    localparam logic [3:0] ALU_MUL     = 4'b0001;
    localparam logic [3:0] ALU_SUB     = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_OR      = 4'b0100;
    localparam logic [3:0] ALU_AND     = 4'b0101;
    localparam logic [3:0] ALU_BNE     = 4'b0110;
    localparam logic [3:0] ALU_BGT     = 4'b0111;
    localparam logic [3:0] ALU_BLT     = 4'b1000;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } alu_state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared one-bit-per-cycle shift-add multiplier / restoring divider.
// Ports: clk, rst_n (async, active low); load latches a, b and is_div and arms the
// counter at WIDTH-1; step advances one iteration; last flags the final iteration;
// lo_next/hi_next are the register values after the current step (product low/high
// or quotient/remainder once last has stepped).
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;

    // Multiply: {hi,lo} starts as {0,A}; add B into hi when lo[0] is set, then shift right.
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: {hi,lo} starts as {0,A}; shift the next dividend bit into the remainder and
    // keep the subtraction unless it borrows. With B=0 every step succeeds, which yields
    // an all-ones quotient and leaves A in the remainder.
    assign rem_sh   = {hi_q, lo_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign last     = cnt_q == '0;
    assign lo_next  = lo_d;
    assign hi_next  = hi_d;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;
        if (load) begin
            hi_d  = '0;
            lo_d  = a;
            b_d   = b;
            div_d = is_div;
            cnt_d = CW'(WIDTH - 1);
        end else if (step) begin
            cnt_d = cnt_q - CW'(1);
            hi_d  = div_q ? (rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0])
                          : mul_sum[WIDTH:1];
            lo_d  = div_q ? {lo_q[WIDTH-2:0], ~rem_diff[WIDTH]}
                          : {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU executing decoded ALU_Control ops with a Start/Busy/Done handshake.
// Ports: Clock, Reset_n (async, active low); Start/ALU_Control/A/B request an op (honoured
// when Busy=0); Busy during iterative mul/div; Done pulses when Result, Result_Hi, Zero,
// Branch_Taken and Invalid have been updated; those outputs hold until the next update.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result_Hi,
    output logic             Zero,
    output logic             Branch_Taken,
    output logic             Invalid
);
    import alu_pkg::*;

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
    logic             zero_q, zero_d, taken_q, taken_d, invalid_q, invalid_d;
    logic [WIDTH-1:0] diff, alu_res, md_lo, md_hi;
    logic             taken, bad, is_iter, md_load, md_step, md_last, upd;

    assign diff    = A - B;
    assign bad     = ALU_Control > ALU_BLT;
    assign is_iter = (ALU_Control == ALU_MUL) || (ALU_Control == ALU_DIV);
    // Sub and all three compares return A-B.
    assign alu_res = bad                      ? '0 :
                     (ALU_Control == ALU_ADD) ? A + B :
                     (ALU_Control == ALU_OR)  ? A | B :
                     (ALU_Control == ALU_AND) ? A & B : diff;
    assign taken   = (ALU_Control == ALU_BNE) ? (A != B) :
                     (ALU_Control == ALU_BGT) ? ($signed(A) > $signed(B)) :
                     (ALU_Control == ALU_BLT) && ($signed(A) < $signed(B));

    assign Busy         = (state_q == S_MUL) || (state_q == S_DIV);
    assign Done         = state_q == S_FINISH;
    assign Result       = result_q;
    assign Result_Hi    = hi_q;
    assign Zero         = zero_q;
    assign Branch_Taken = taken_q;
    assign Invalid      = invalid_q;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (Clock),
        .rst_n   (Reset_n),
        .load    (md_load),
        .is_div  (ALU_Control == ALU_DIV),
        .step    (md_step),
        .a       (A),
        .b       (B),
        .last    (md_last),
        .lo_next (md_lo),
        .hi_next (md_hi)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        hi_d      = hi_q;
        taken_d   = taken_q;
        invalid_d = invalid_q;
        md_load   = 1'b0;
        md_step   = 1'b0;
        upd       = 1'b0;
        case (state_q)
            S_MUL, S_DIV: begin
                md_step = 1'b1;
                if (md_last) begin
                    state_d   = S_FINISH;
                    result_d  = md_lo;
                    hi_d      = md_hi;
                    taken_d   = 1'b0;
                    invalid_d = 1'b0;
                    upd       = 1'b1;
                end
            end
            default: begin
                // IDLE and FINISH both accept a new request, so Done can overlap the next Start.
                state_d = S_IDLE;
                if (Start) begin
                    md_load = is_iter;
                    state_d = (ALU_Control == ALU_MUL) ? S_MUL :
                              (ALU_Control == ALU_DIV) ? S_DIV : S_FINISH;
                    if (!is_iter) begin
                        result_d  = alu_res;
                        hi_d      = '0;
                        taken_d   = taken;
                        invalid_d = bad;
                        upd       = 1'b1;
                    end
                end
            end
        endcase
        // Zero only tracks Result on updates, so it stays 0 out of reset.
        zero_d = upd ? (result_d == '0) : zero_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            taken_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            zero_q    <= zero_d;
            taken_q   <= taken_d;
            invalid_q <= invalid_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + model-checked bench for alu_exec_unit.
module tb_alu_exec_unit;
    localparam int W = 32;
    localparam logic [3:0] C_DIV = 4'b0000, C_MUL = 4'b0001, C_SUB = 4'b0010, C_ADD = 4'b0011;
    localparam logic [3:0] C_OR = 4'b0100, C_AND = 4'b0101, C_BNE = 4'b0110, C_BGT = 4'b0111;
    localparam logic [3:0] C_BLT = 4'b1000;

    logic         Clock = 1'b0, Reset_n = 1'b1, Start = 1'b0;
    logic [3:0]   ALU_Control = 4'b0;
    logic [W-1:0] A = '0, B = '0;
    logic         Busy, Done, Zero, Branch_Taken, Invalid;
    logic [W-1:0] Result, Result_Hi;

    int checks = 0, errors = 0;
    int lat, bsy;

    alu_exec_unit #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .ALU_Control(ALU_Control),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result), .Result_Hi(Result_Hi),
        .Zero(Zero), .Branch_Taken(Branch_Taken), .Invalid(Invalid)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: accepted ops complete after a fixed latency with values
    // from plain arithmetic.
    logic         m_busy = 0, m_done = 0, m_zero = 0, m_br = 0, m_inv = 0, m_acc;
    logic [W-1:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;
    logic [63:0]  m_prod;
    int           m_cnt = 0;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            {m_busy, m_done, m_zero, m_br, m_inv} = '0;
            m_res = '0; m_hi = '0; m_cnt = 0;
        end else begin
            m_acc  = Start && !m_busy;
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_res = p_res; m_hi = p_hi; m_zero = (p_res == 0);
                    m_br = 1'b0; m_inv = 1'b0; m_done = 1'b1;
                end
            end
            if (m_acc) begin
                if (ALU_Control == C_MUL) begin
                    m_prod = {32'b0, A} * {32'b0, B};
                    p_res = m_prod[31:0]; p_hi = m_prod[63:32]; m_cnt = W;
                end else if (ALU_Control == C_DIV) begin
                    p_res = (B == 0) ? 32'hFFFF_FFFF : A / B;
                    p_hi  = (B == 0) ? A : A % B;
                    m_cnt = W;
                end else begin
                    m_hi = '0; m_br = 1'b0; m_inv = 1'b0; m_done = 1'b1;
                    case (ALU_Control)
                        C_ADD:   m_res = A + B;
                        C_SUB:   m_res = A - B;
                        C_OR:    m_res = A | B;
                        C_AND:   m_res = A & B;
                        C_BNE:   begin m_res = A - B; m_br = A != B; end
                        C_BGT:   begin m_res = A - B; m_br = $signed(A) > $signed(B); end
                        C_BLT:   begin m_res = A - B; m_br = $signed(A) < $signed(B); end
                        default: begin m_res = '0; m_inv = 1'b1; end
                    endcase
                    m_zero = (m_res == 0);
                end
            end
            m_busy = m_cnt > 0;
        end
    end

    always @(negedge Clock) begin
        check("cyc_busy", Busy, m_busy);
        check("cyc_done", Done, m_done);
        check("cyc_result", Result, m_res);
        check("cyc_result_hi", Result_Hi, m_hi);
        check("cyc_zero", Zero, m_zero);
        check("cyc_branch", Branch_Taken, m_br);
        check("cyc_invalid", Invalid, m_inv);
    end

    // One request; lat counts negedges after the accepting edge until Done, busy_n the Busy ones.
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject, output int lat_o, output int busy_n);
        @(posedge Clock); #1;
        ALU_Control = c; A = a; B = b; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        lat_o = 0; busy_n = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            if (Busy) busy_n++;
            if (Done) begin lat_o = n; break; end
            if (inject && n == 5) begin Start = 1'b1; ALU_Control = C_ADD; A = 1; B = 1; end
            if (inject && n == 6) begin Start = 1'b0; A = 0; B = 0; end
        end
        if (lat_o == 0) check("done_seen", Done, 1);
    endtask

    initial begin
        #1 Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        check("rst_result", Result, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_zero", Zero, 0);
        #2 Reset_n = 1'b1;

        // add wrap, then sub accepted in the cycle Done is high
        @(posedge Clock); #1;
        Start = 1'b1; ALU_Control = C_ADD; A = 32'hFFFF_FFFF; B = 1;
        @(posedge Clock);
        @(negedge Clock);
        check("add_wrap_done", Done, 1);
        check("add_wrap_result", Result, 0);
        check("add_wrap_zero", Zero, 1);
        ALU_Control = C_SUB; A = 5; B = 7;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(negedge Clock);
        check("b2b_sub_done", Done, 1);
        check("sub_result", Result, 32'hFFFF_FFFE);
        check("sub_zero", Zero, 0);
        @(negedge Clock);
        check("done_one_cycle", Done, 0);

        // reset in the middle of a divide
        @(posedge Clock); #1;
        Start = 1'b1; ALU_Control = C_DIV; A = 100; B = 7;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(negedge Clock);
        check("busy_before_reset", Busy, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_result", Result, 0);
        check("midrst_result_hi", Result_Hi, 0);
        check("midrst_zero", Zero, 0);
        @(negedge Clock); #2 Reset_n = 1'b1;
        issue(C_ADD, 3, 4, 0, lat, bsy);
        check("add_lat", lat, 1);
        check("add_result", Result, 7);
        check("add_busy_cycles", bsy, 0);

        issue(C_MUL, 32'h1_0000, 32'h1_0000, 1, lat, bsy);
        check("mul_lat", lat, 33);
        check("mul_busy_cycles", bsy, 32);
        check("mul_result", Result, 0);
        check("mul_result_hi", Result_Hi, 1);

        issue(C_DIV, 100, 7, 0, lat, bsy);
        check("div_lat", lat, 33);
        check("div_result", Result, 14);
        check("div_result_hi", Result_Hi, 2);
        issue(C_DIV, 9, 0, 0, lat, bsy);
        check("div0_lat", lat, 33);
        check("div0_result", Result, 32'hFFFF_FFFF);
        check("div0_result_hi", Result_Hi, 9);

        issue(C_BGT, 1, 32'hFFFF_FFFF, 0, lat, bsy);
        check("bgt_taken", Branch_Taken, 1);
        check("bgt_result", Result, 2);
        issue(C_BLT, 1, 32'hFFFF_FFFF, 0, lat, bsy);
        check("blt_taken", Branch_Taken, 0);
        issue(C_BNE, 5, 5, 0, lat, bsy);
        check("bne_taken", Branch_Taken, 0);
        check("bne_zero", Zero, 1);

        issue(C_OR, 32'hF0F0, 32'h0F0F, 0, lat, bsy);
        check("or_result", Result, 32'hFFFF);
        issue(C_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, lat, bsy);
        check("and_result", Result, 32'h0F00_0F00);

        issue(4'b1001, 12, 34, 0, lat, bsy);
        check("inv_lat", lat, 1);
        check("inv_flag", Invalid, 1);
        check("inv_result", Result, 0);
        check("inv_result_hi", Result_Hi, 0);
        issue(C_ADD, 2, 2, 0, lat, bsy);
        check("inv_cleared", Invalid, 0);
        check("add2_result", Result, 4);

        for (int i = 0; i < 4; i++) begin
            issue(C_MUL, $urandom, $urandom, 0, lat, bsy);
            issue(C_DIV, $urandom, $urandom_range(1, 1000), 0, lat, bsy);
        end

        repeat (3) @(negedge Clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
